l2tlb_l1port: RTL and testbench
===============================

Name: l2tlb_l1port

Overview:
- L2-TLB-side responder for one L1 data TLB.
- Accepts L1 translation requests (l1tlbtol2tlb_req) and answers each with an ack (l2tlbtol1tlb_ack) from a small fully-associative translation store.
- Installs fills from the page walker. When a valid entry is displaced, it issues a snoop (l2tlbtol1tlb_snoop) to the L1 and waits for the L1 sack before reusing the slot.
- hpaddr is the entry index; it identifies the L2TLB entry to the L1.

Parameters:
- ENTRIES, 16, number of translation entries (power of 2).
- HPW, 4, hpaddr width = log2(ENTRIES).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- l1tlbtol2tlb_req_valid  in  1  request valid
- l1tlbtol2tlb_req_retry  out  1  request back-pressure
- l1tlbtol2tlb_req  in  $bits(I_l1tlbtol2tlb_req_type)  {l1id, coreid, vpn}
- l2tlbtol1tlb_ack_valid  out  1  ack valid
- l2tlbtol1tlb_ack_retry  in  1  ack back-pressure
- l2tlbtol1tlb_ack  out  $bits(I_l2tlbtol1tlb_ack_type)  {l1id, hit, hpaddr, ppn}
- l2tlbtol1tlb_snoop_valid  out  1  snoop valid
- l2tlbtol1tlb_snoop_retry  in  1  snoop back-pressure
- l2tlbtol1tlb_snoop  out  $bits(I_l2tlbtol1tlb_snoop_type)  {hpaddr}
- l1tlbtol2tlb_sack_valid  in  1  snoop ack valid
- l1tlbtol2tlb_sack_retry  out  1  sack back-pressure (held 0)
- l1tlbtol2tlb_sack  in  $bits(I_l1tlbtol2tlb_sack_type)  {hpaddr}
- ptwtol2tlb_fill_valid  in  1  fill valid
- ptwtol2tlb_fill_retry  out  1  fill back-pressure
- ptwtol2tlb_fill  in  $bits(I_ptwtol2tlb_fill_type)  {vpn, ppn}

Behaviour:
- Handshake: a transfer occurs when valid=1 and retry=0. A sender holds valid and payload stable while retry=1.
- Reset (reset=0, async): all entry valid bits cleared, victim pointer=0, FSM=IDLE. ack_valid=0, snoop_valid=0, req_retry=0, fill_retry=0, sack_retry=0. Reset mid-eviction abandons the eviction; no snoop or ack survives.
- Lookup:
  - A request accepted in cycle N compares vpn against all entries with valid=1 and evicting=0.
  - Result is registered; ack_valid=1 in cycle N+1.
  - Hit: hit=1, hpaddr=index, ppn=entry ppn. Miss: hit=0, hpaddr=0, ppn=0. l1id is echoed in both cases.
- Output stage: single register. req_retry = ack_valid & ack_retry. An ack held under retry keeps its payload unchanged.
- Same-cycle fill write and lookup of the same vpn: the lookup sees pre-write contents (miss).
- Fill FSM states:
  - IDLE: fill_retry=0.
    - If the fill vpn matches a valid entry: update ppn in place, no snoop, stay IDLE.
    - Else if the victim (pointer) entry is invalid: write it, pointer+1 (wraps at ENTRIES-1 -> 0), stay IDLE.
    - Else: latch the fill, set the victim's evicting=1, go to SNOOP.
  - SNOOP: fill_retry=1, snoop_valid=1, hpaddr=victim. On transfer -> WAIT_SACK.
  - WAIT_SACK: fill_retry=1.
    - sack with hpaddr==victim: write the latched fill into the victim, clear evicting, pointer+1, -> IDLE.
    - sack with a mismatched hpaddr: consumed and ignored.
- An evicting entry never hits, so no new ack carries that hpaddr after the snoop is launched.
- Acks already sent before eviction began may precede the snoop; the L1 orders them.
- sack_retry is always 0; sacks are accepted in every state and ignored outside WAIT_SACK.

Decomposition:
- Package l2tlb_pkg holds:
  - the types I_l1tlbtol2tlb_req_type, I_l2tlbtol1tlb_ack_type, I_l2tlbtol1tlb_snoop_type, I_l1tlbtol2tlb_sack_type, I_ptwtol2tlb_fill_type;
  - VPN/PPN width constants;
  - the FSM state enum.
- Sub-module l2tlb_cam: entry storage plus parallel vpn match. It returns hit and index, and takes write and evicting-set/clear ports.
- The output register reuses the codebase fflop.

Test Plan:
- Reset then request vpn=0x12, l1id=3 -> next cycle ack {l1id=3, hit=0, hpaddr=0, ppn=0}.
- Fill {vpn=0x12, ppn=0x80}, then request vpn=0x12 -> ack {hit=1, hpaddr=0, ppn=0x80}; no snoop.
- Fill 17 distinct vpns (ENTRIES=16):
  - the 17th -> snoop hpaddr=0 and fill_retry=1;
  - a request for entry 0's vpn during WAIT_SACK -> hit=0;
  - sack hpaddr=0 -> the new vpn hits at hpaddr=0, and the next victim is 1.
- Hold ack_retry=1 for 3 cycles with a second request pending -> req_retry=1 and the ack payload stable; release -> both acks delivered in order.
- In WAIT_SACK send sack hpaddr=5 (victim 0) -> ignored and the FSM stays; then sack hpaddr=0 -> return to IDLE.
- Assert reset=0 during SNOOP -> snoop_valid=0 immediately; after release all lookups miss and the victim pointer is 0.

Source files
------------

// File: rtl/l2tlb_pkg.sv
// Shared types and widths for the L2TLB <-> L1 data TLB port.
package l2tlb_pkg;

  localparam int unsigned VPN_W    = 20;
  localparam int unsigned PPN_W    = 20;
  localparam int unsigned L1ID_W   = 5;
  localparam int unsigned CORE_W   = 2;
  localparam int unsigned HPADDR_W = 4;

  typedef struct packed {
    logic [L1ID_W-1:0] l1id;
    logic [CORE_W-1:0] coreid;
    logic [VPN_W-1:0]  vpn;
  } I_l1tlbtol2tlb_req_type;

  typedef struct packed {
    logic [L1ID_W-1:0]   l1id;
    logic                hit;
    logic [HPADDR_W-1:0] hpaddr;
    logic [PPN_W-1:0]    ppn;
  } I_l2tlbtol1tlb_ack_type;

  typedef struct packed {
    logic [HPADDR_W-1:0] hpaddr;
  } I_l2tlbtol1tlb_snoop_type;

  typedef struct packed {
    logic [HPADDR_W-1:0] hpaddr;
  } I_l1tlbtol2tlb_sack_type;

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } I_ptwtol2tlb_fill_type;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_SNOOP,
    FILL_WAIT_SACK
  } fill_state_t;

endpackage

// File: rtl/fflop.sv
// Single-entry valid/retry pipeline register.
module fflop #(
  parameter int unsigned Size = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Size-1:0] din,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [Size-1:0] q,
  output logic            qValid,
  input  logic            qRetry
);

  logic            r_valid;
  logic [Size-1:0] r_data;

  assign dinRetry = r_valid & qRetry;
  assign qValid   = r_valid;
  assign q        = r_data;

  // Load a new beat whenever the held one is not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!dinRetry) begin
      r_valid <= dinValid;
      if (dinValid) r_data <= din;
    end
  end

endmodule

// File: rtl/l2tlb_cam.sv
// Fully-associative translation store with two parallel vpn match ports.
module l2tlb_cam
  import l2tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned HPW     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VPN_W-1:0]   i_lkp_vpn,
  output logic               o_lkp_hit,
  output logic [HPW-1:0]     o_lkp_idx,
  output logic [PPN_W-1:0]   o_lkp_ppn,
  input  logic [VPN_W-1:0]   i_fill_vpn,
  output logic               o_fill_hit,
  output logic [HPW-1:0]     o_fill_idx,
  output logic [ENTRIES-1:0] o_valid,
  input  logic               i_we,
  input  logic [HPW-1:0]     i_widx,
  input  logic [VPN_W-1:0]   i_wvpn,
  input  logic [PPN_W-1:0]   i_wppn,
  input  logic               i_ev_set,
  input  logic               i_ev_clr,
  input  logic [HPW-1:0]     i_ev_idx
);

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_evict;
  logic [VPN_W-1:0]   r_vpn [ENTRIES];
  logic [PPN_W-1:0]   r_ppn [ENTRIES];

  assign o_valid = r_valid;

  // Parallel match; lookups skip entries being evicted, fills see every valid entry.
  always_comb begin
    o_lkp_hit  = 1'b0;
    o_lkp_idx  = '0;
    o_lkp_ppn  = '0;
    o_fill_hit = 1'b0;
    o_fill_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && !r_evict[i] && r_vpn[i] == i_lkp_vpn) begin
        o_lkp_hit = 1'b1;
        o_lkp_idx = HPW'(i);
        o_lkp_ppn = r_ppn[i];
      end
      if (r_valid[i] && r_vpn[i] == i_fill_vpn) begin
        o_fill_hit = 1'b1;
        o_fill_idx = HPW'(i);
      end
    end
  end

  // Valid and evicting flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_evict <= '0;
    end else begin
      if (i_we) r_valid[i_widx] <= 1'b1;
      if (i_ev_set)      r_evict[i_ev_idx] <= 1'b1;
      else if (i_ev_clr) r_evict[i_ev_idx] <= 1'b0;
    end
  end

  // Entry payload; meaningful only while the valid flag is set.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_vpn[i_widx] <= i_wvpn;
      r_ppn[i_widx] <= i_wppn;
    end
  end

endmodule

// File: rtl/l2tlb_l1port.sv
// L2TLB responder for one L1 data TLB: lookups, fills and snoop-guarded eviction.
module l2tlb_l1port
  import l2tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned HPW     = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       l1tlbtol2tlb_req_valid,
  output logic                                       l1tlbtol2tlb_req_retry,
  input  logic [$bits(I_l1tlbtol2tlb_req_type)-1:0]   l1tlbtol2tlb_req,
  output logic                                       l2tlbtol1tlb_ack_valid,
  input  logic                                       l2tlbtol1tlb_ack_retry,
  output logic [$bits(I_l2tlbtol1tlb_ack_type)-1:0]   l2tlbtol1tlb_ack,
  output logic                                       l2tlbtol1tlb_snoop_valid,
  input  logic                                       l2tlbtol1tlb_snoop_retry,
  output logic [$bits(I_l2tlbtol1tlb_snoop_type)-1:0] l2tlbtol1tlb_snoop,
  input  logic                                       l1tlbtol2tlb_sack_valid,
  output logic                                       l1tlbtol2tlb_sack_retry,
  input  logic [$bits(I_l1tlbtol2tlb_sack_type)-1:0]  l1tlbtol2tlb_sack,
  input  logic                                       ptwtol2tlb_fill_valid,
  output logic                                       ptwtol2tlb_fill_retry,
  input  logic [$bits(I_ptwtol2tlb_fill_type)-1:0]    ptwtol2tlb_fill
);

  I_l1tlbtol2tlb_req_type  w_req;
  I_l1tlbtol2tlb_sack_type w_sack;
  I_ptwtol2tlb_fill_type   w_fill;
  I_l2tlbtol1tlb_ack_type  w_ack_d;
  logic [CORE_W-1:0]       w_unused_coreid;

  logic                    w_lkp_hit;
  logic [HPW-1:0]          w_lkp_idx;
  logic [PPN_W-1:0]        w_lkp_ppn;
  logic                    w_fill_hit;
  logic [HPW-1:0]          w_fill_idx;
  logic [ENTRIES-1:0]      w_valid;

  logic                    w_we;
  logic [HPW-1:0]          w_widx;
  logic [VPN_W-1:0]        w_wvpn;
  logic [PPN_W-1:0]        w_wppn;
  logic                    w_ev_set;
  logic                    w_ev_clr;
  logic                    w_ptr_inc;
  logic                    w_latch;

  fill_state_t             r_state;
  fill_state_t             w_state_nxt;
  logic [HPW-1:0]          r_ptr;
  I_ptwtol2tlb_fill_type   r_fill;

  assign w_req                   = l1tlbtol2tlb_req;
  assign w_sack                  = l1tlbtol2tlb_sack;
  assign w_fill                  = ptwtol2tlb_fill;
  assign w_unused_coreid         = w_req.coreid;
  assign l1tlbtol2tlb_sack_retry = 1'b0;
  assign l2tlbtol1tlb_snoop      = HPADDR_W'(r_ptr);

  l2tlb_cam #(
    .ENTRIES (ENTRIES),
    .HPW     (HPW)
  ) u_cam (
    .clk        (clk),
    .reset      (reset),
    .i_lkp_vpn  (w_req.vpn),
    .o_lkp_hit  (w_lkp_hit),
    .o_lkp_idx  (w_lkp_idx),
    .o_lkp_ppn  (w_lkp_ppn),
    .i_fill_vpn (w_fill.vpn),
    .o_fill_hit (w_fill_hit),
    .o_fill_idx (w_fill_idx),
    .o_valid    (w_valid),
    .i_we       (w_we),
    .i_widx     (w_widx),
    .i_wvpn     (w_wvpn),
    .i_wppn     (w_wppn),
    .i_ev_set   (w_ev_set),
    .i_ev_clr   (w_ev_clr),
    .i_ev_idx   (r_ptr)
  );

  // Ack payload built from the lookup result; misses report zero index and ppn.
  always_comb begin
    w_ack_d        = '0;
    w_ack_d.l1id   = w_req.l1id;
    w_ack_d.hit    = w_lkp_hit;
    w_ack_d.hpaddr = w_lkp_hit ? HPADDR_W'(w_lkp_idx) : '0;
    w_ack_d.ppn    = w_lkp_hit ? w_lkp_ppn : '0;
  end

  fflop #(
    .Size ($bits(I_l2tlbtol1tlb_ack_type))
  ) u_ack_ff (
    .clk      (clk),
    .reset    (reset),
    .din      (w_ack_d),
    .dinValid (l1tlbtol2tlb_req_valid),
    .dinRetry (l1tlbtol2tlb_req_retry),
    .q        (l2tlbtol1tlb_ack),
    .qValid   (l2tlbtol1tlb_ack_valid),
    .qRetry   (l2tlbtol1tlb_ack_retry)
  );

  // Fill FSM next-state, CAM write control and handshake outputs.
  always_comb begin
    w_state_nxt              = r_state;
    w_we                     = 1'b0;
    w_widx                   = r_ptr;
    w_wvpn                   = w_fill.vpn;
    w_wppn                   = w_fill.ppn;
    w_ev_set                 = 1'b0;
    w_ev_clr                 = 1'b0;
    w_ptr_inc                = 1'b0;
    w_latch                  = 1'b0;
    ptwtol2tlb_fill_retry    = 1'b0;
    l2tlbtol1tlb_snoop_valid = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (ptwtol2tlb_fill_valid) begin
          if (w_fill_hit) begin
            w_we   = 1'b1;
            w_widx = w_fill_idx;
          end else if (!w_valid[r_ptr]) begin
            w_we      = 1'b1;
            w_ptr_inc = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_ev_set    = 1'b1;
            w_state_nxt = FILL_SNOOP;
          end
        end
      end
      FILL_SNOOP: begin
        ptwtol2tlb_fill_retry    = 1'b1;
        l2tlbtol1tlb_snoop_valid = 1'b1;
        if (!l2tlbtol1tlb_snoop_retry) w_state_nxt = FILL_WAIT_SACK;
      end
      FILL_WAIT_SACK: begin
        ptwtol2tlb_fill_retry = 1'b1;
        if (l1tlbtol2tlb_sack_valid && w_sack.hpaddr == HPADDR_W'(r_ptr)) begin
          w_we        = 1'b1;
          w_wvpn      = r_fill.vpn;
          w_wppn      = r_fill.ppn;
          w_ev_clr    = 1'b1;
          w_ptr_inc   = 1'b1;
          w_state_nxt = FILL_IDLE;
        end
      end
      default: w_state_nxt = FILL_IDLE;
    endcase
  end

  // Fill FSM state, victim pointer and the fill parked during eviction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL_IDLE;
      r_ptr   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ptr_inc) r_ptr  <= r_ptr + HPW'(1);
      if (w_latch)   r_fill <= w_fill;
    end
  end

endmodule

// File: tb/tb_l2tlb_l1port.sv
// Self-checking bench for l2tlb_l1port.
module tb_l2tlb_l1port;
  import l2tlb_pkg::*;

  typedef struct {
    logic [VPN_W-1:0]    vpn;
    logic [L1ID_W-1:0]   l1id;
    logic                hit;
    logic [HPADDR_W-1:0] hp;
    logic [PPN_W-1:0]    ppn;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     req_valid, req_retry;
  I_l1tlbtol2tlb_req_type   req;
  logic                     ack_valid, ack_retry;
  I_l2tlbtol1tlb_ack_type   ack;
  logic                     snoop_valid, snoop_retry;
  I_l2tlbtol1tlb_snoop_type snoop;
  logic                     sack_valid, sack_retry;
  I_l1tlbtol2tlb_sack_type  sack;
  logic                     fill_valid, fill_retry;
  I_ptwtol2tlb_fill_type    fill;

  I_l2tlbtol1tlb_ack_type   q_exp[$];
  I_l2tlbtol1tlb_ack_type   m_exp;
  I_l2tlbtol1tlb_ack_type   held;
  I_l2tlbtol1tlb_ack_type   e_b;
  int                       n_checks = 0;
  int                       n_err = 0;
  vec_t                     tbl[6];
  vec_t                     post[3];

  always #5 clk = ~clk;

  l2tlb_l1port #(
    .ENTRIES (16),
    .HPW     (4)
  ) dut (
    .clk                      (clk),
    .reset                    (rst_n),
    .l1tlbtol2tlb_req_valid   (req_valid),
    .l1tlbtol2tlb_req_retry   (req_retry),
    .l1tlbtol2tlb_req         (req),
    .l2tlbtol1tlb_ack_valid   (ack_valid),
    .l2tlbtol1tlb_ack_retry   (ack_retry),
    .l2tlbtol1tlb_ack         (ack),
    .l2tlbtol1tlb_snoop_valid (snoop_valid),
    .l2tlbtol1tlb_snoop_retry (snoop_retry),
    .l2tlbtol1tlb_snoop       (snoop),
    .l1tlbtol2tlb_sack_valid  (sack_valid),
    .l1tlbtol2tlb_sack_retry  (sack_retry),
    .l1tlbtol2tlb_sack        (sack),
    .ptwtol2tlb_fill_valid    (fill_valid),
    .ptwtol2tlb_fill_retry    (fill_retry),
    .ptwtol2tlb_fill          (fill)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every delivered ack must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ack_valid && !ack_retry) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL ack_unexpected: got 0x%0h with no ack expected", ack);
      end else begin
        m_exp = q_exp.pop_front();
        chk("ack", ack, m_exp);
      end
    end
  end

  task automatic send_req(input logic [VPN_W-1:0] vpn, input logic [L1ID_W-1:0] id,
                          input logic hit, input logic [HPADDR_W-1:0] hp,
                          input logic [PPN_W-1:0] ppn);
    I_l2tlbtol1tlb_ack_type e;
    bit done;
    done     = 1'b0;
    e.l1id   = id;
    e.hit    = hit;
    e.hpaddr = hp;
    e.ppn    = ppn;
    req_valid  = 1'b1;
    req.l1id   = id;
    req.coreid = 2'd1;
    req.vpn    = vpn;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!req_retry) begin
        q_exp.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    chk("req_accept", done, 1);
  endtask

  task automatic send_fill(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn);
    bit done;
    done       = 1'b0;
    fill_valid = 1'b1;
    fill.vpn   = vpn;
    fill.ppn   = ppn;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!fill_retry) done = 1'b1;
      @(posedge clk); #2;
    end
    fill_valid = 1'b0;
    chk("fill_accept", done, 1);
  endtask

  task automatic send_sack(input logic [HPADDR_W-1:0] hp);
    sack_valid  = 1'b1;
    sack.hpaddr = hp;
    @(posedge clk); #2;
    sack_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q_exp.size() != 0; k++) @(posedge clk);
    #2;
    chk("drain", q_exp.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{20'h00012, 5'd2, 1'b1, 4'd0,  20'h00080};
    tbl[1] = '{20'h00101, 5'd4, 1'b1, 4'd1,  20'h00201};
    tbl[2] = '{20'h0010F, 5'd5, 1'b1, 4'd15, 20'h0020F};
    tbl[3] = '{20'h00108, 5'd6, 1'b1, 4'd8,  20'h00208};
    tbl[4] = '{20'h00999, 5'd7, 1'b0, 4'd0,  20'h00000};
    tbl[5] = '{20'h00110, 5'd8, 1'b0, 4'd0,  20'h00000};
    post[0] = '{20'h00500, 5'd20, 1'b0, 4'd0, 20'h00000};
    post[1] = '{20'h00501, 5'd21, 1'b0, 4'd0, 20'h00000};
    post[2] = '{20'h0010F, 5'd22, 1'b0, 4'd0, 20'h00000};

    rst_n = 1'b0;
    req_valid = 1'b0; req = '0; ack_retry = 1'b0;
    snoop_retry = 1'b0; sack_valid = 1'b0; sack = '0;
    fill_valid = 1'b0; fill = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_snoop_valid", snoop_valid, 0);
    chk("rst_req_retry", req_retry, 0);
    chk("rst_fill_retry", fill_retry, 0);
    chk("rst_sack_retry", sack_retry, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Miss on an empty store, ack one cycle after acceptance.
    send_req(20'h00012, 5'd3, 1'b0, 4'd0, 20'h0);
    chk("ack_latency", ack_valid, 1);
    drain();

    // Install into slot 0, then hit it.
    send_fill(20'h00012, 20'h00080);
    send_req(20'h00012, 5'd1, 1'b1, 4'd0, 20'h00080);
    chk("no_snoop_on_free_slot", snoop_valid, 0);
    drain();

    // Fill slots 1..15; pointer wraps back to 0.
    for (int unsigned i = 1; i < 16; i++)
      send_fill(VPN_W'(32'h100 + i), PPN_W'(32'h200 + i));
    chk("no_snoop_while_filling", snoop_valid, 0);

    // Back-to-back lookups from the table.
    for (int unsigned i = 0; i < 6; i++)
      send_req(tbl[i].vpn, tbl[i].l1id, tbl[i].hit, tbl[i].hp, tbl[i].ppn);
    drain();

    // Fill of a resident vpn updates in place without snooping.
    send_fill(20'h00108, 20'h003A8);
    chk("inplace_no_snoop", snoop_valid, 0);
    chk("inplace_no_retry", fill_retry, 0);
    send_req(20'h00108, 5'd11, 1'b1, 4'd8, 20'h003A8);
    drain();

    // Ack held under retry while a second request waits.
    ack_retry = 1'b1;
    send_req(20'h00101, 5'd9, 1'b1, 4'd1, 20'h00201);
    held       = ack;
    req_valid  = 1'b1;
    req.l1id   = 5'd10;
    req.coreid = 2'd0;
    req.vpn    = 20'h0010F;
    e_b        = '{l1id: 5'd10, hit: 1'b1, hpaddr: 4'd15, ppn: 20'h0020F};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_req_retry", req_retry, 1);
      chk("hold_ack_valid", ack_valid, 1);
      chk("hold_ack_payload", ack, held);
      @(posedge clk); #2;
    end
    ack_retry = 1'b0;
    @(negedge clk);
    chk("release_req_retry", req_retry, 0);
    if (!req_retry) q_exp.push_back(e_b);
    @(posedge clk); #2;
    req_valid = 1'b0;
    drain();

    // 17th distinct vpn evicts slot 0.
    send_fill(20'h00500, 20'h00600);
    chk("evict_snoop_valid", snoop_valid, 1);
    chk("evict_snoop_hpaddr", snoop, 4'd0);
    chk("evict_fill_retry", fill_retry, 1);
    @(posedge clk); #2;
    chk("wait_snoop_dropped", snoop_valid, 0);
    send_req(20'h00012, 5'd12, 1'b0, 4'd0, 20'h0);
    drain();
    send_sack(4'd5);
    chk("bad_sack_ignored", fill_retry, 1);
    chk("sack_retry_zero", sack_retry, 0);
    send_sack(4'd0);
    chk("good_sack_idle", fill_retry, 0);
    send_req(20'h00500, 5'd13, 1'b1, 4'd0, 20'h00600);
    send_req(20'h00012, 5'd14, 1'b0, 4'd0, 20'h0);
    drain();

    // Next victim is slot 1; snoop holds under back-pressure.
    snoop_retry = 1'b1;
    send_fill(20'h00501, 20'h00601);
    chk("evict2_snoop_hpaddr", snoop, 4'd1);
    @(posedge clk); #2;
    chk("snoop_hold_valid", snoop_valid, 1);
    chk("snoop_hold_hpaddr", snoop, 4'd1);
    snoop_retry = 1'b0;
    @(posedge clk); #2;
    chk("evict2_wait", snoop_valid, 0);
    send_sack(4'd1);
    send_req(20'h00501, 5'd15, 1'b1, 4'd1, 20'h00601);
    drain();

    // Reset during SNOOP abandons the eviction.
    snoop_retry = 1'b1;
    send_fill(20'h00502, 20'h00602);
    chk("evict3_snoop_valid", snoop_valid, 1);
    chk("evict3_snoop_hpaddr", snoop, 4'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_snoop_valid", snoop_valid, 0);
    chk("midrst_fill_retry", fill_retry, 0);
    chk("midrst_ack_valid", ack_valid, 0);
    snoop_retry = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    for (int unsigned i = 0; i < 3; i++)
      send_req(post[i].vpn, post[i].l1id, post[i].hit, post[i].hp, post[i].ppn);
    drain();
    send_fill(20'h00700, 20'h00701);
    chk("post_rst_no_snoop", snoop_valid, 0);
    send_req(20'h00700, 5'd23, 1'b1, 4'd0, 20'h00701);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
